video_timing_src: RTL and testbench

//  Synthesizable video source: generates vsync/hsync/de plus 10-bit RGB test patterns.

---
 rtl/video_pkg.sv | 6 +
 rtl/video_pattern_gen.sv | 47 ++++
 rtl/video_timing_src.sv | 127 ++++++++++++
 tb/tb_video_timing_src.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared types and widths for the video test-pattern source.
package video_pkg;
   localparam int DW = 10;
   typedef enum logic [1:0] {PAT_RAMP, PAT_BARS, PAT_CHECK, PAT_BLACK} pat_e;
   typedef enum logic {ST_IDLE, ST_RUN} state_e;
endpackage

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: maps active-area position and frame index to RGB test-pattern pixels.
module video_pattern_gen import video_pkg::*; #(
   parameter int HACT = 10
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [DW-1:0] i_x,
   input  logic [DW-1:0] i_y,
   input  logic [DW-1:0] i_frame,
   input  pat_e          i_pat,
   input  logic          i_de,
   output logic [DW-1:0] o_r,
   output logic [DW-1:0] o_g,
   output logic [DW-1:0] o_b
);
   localparam int BW  = (HACT / 8 < 1) ? 1 : HACT / 8;
   localparam int BCW = (BW > 1) ? $clog2(BW) : 1;
   localparam logic [BCW-1:0] B_LAST = BCW'(BW - 1);

   logic [BCW-1:0] bar_cnt;
   logic [2:0]     bar_idx;
   logic [DW-1:0]  chk;

   // Bar index tracks x / BW incrementally; it rests at 0 outside the active area.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (!i_de) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (bar_cnt == B_LAST) begin
         bar_cnt <= '0;
         bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
      end else begin
         bar_cnt <= bar_cnt + 1'b1;
      end
   end

   assign chk = {DW{i_x[3] ^ i_y[3]}};

   always_comb begin
      o_r = !i_de ? '0 : i_pat == PAT_RAMP ? i_x     : i_pat == PAT_BARS ? {DW{~bar_idx[1]}} : i_pat == PAT_CHECK ? chk : '0;
      o_g = !i_de ? '0 : i_pat == PAT_RAMP ? i_y     : i_pat == PAT_BARS ? {DW{~bar_idx[2]}} : i_pat == PAT_CHECK ? chk : '0;
      o_b = !i_de ? '0 : i_pat == PAT_RAMP ? i_frame : i_pat == PAT_BARS ? {DW{~bar_idx[0]}} : i_pat == PAT_CHECK ? chk : '0;
   end
endmodule

// File: rtl/video_timing_src.sv
// video_timing_src: frame-based vsync/hsync/de generator with selectable 10-bit RGB test patterns.
module video_timing_src import video_pkg::*; #(
   parameter bit VSYNC_POL = 1'b0,
   parameter bit HSYNC_POL = 1'b0,
   parameter int VSW  = 1,
   parameter int VBP  = 1,
   parameter int VACT = 4,
   parameter int VFP  = 1,
   parameter int HSW  = 1,
   parameter int HBP  = 2,
   parameter int HACT = 10,
   parameter int HFP  = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_start,
   input  logic          i_stop,
   input  logic [7:0]    i_nframes,
   input  logic [1:0]    i_pat_sel,
   output logic          o_busy,
   output logic          o_frame_done,
   output logic          o_vsync,
   output logic          o_hsync,
   output logic          o_de,
   output logic [DW-1:0] o_r_data,
   output logic [DW-1:0] o_g_data,
   output logic [DW-1:0] o_b_data
);
   localparam int HTOT = HSW + HBP + HACT + HFP;
   localparam int VTOT = VSW + VBP + VACT + VFP;
   localparam int HW   = $clog2(HTOT);
   localparam int VW   = $clog2(VTOT);
   localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
   localparam logic [HW-1:0] H_SW   = HW'(HSW);
   localparam logic [HW-1:0] H_A0   = HW'(HSW + HBP);
   localparam logic [HW-1:0] H_A1   = HW'(HSW + HBP + HACT);
   localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
   localparam logic [VW-1:0] V_SW   = VW'(VSW);
   localparam logic [VW-1:0] V_A0   = VW'(VSW + VBP);
   localparam logic [VW-1:0] V_A1   = VW'(VSW + VBP + VACT);

   state_e        state;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [DW-1:0] frame_cnt, x, y, r_c, g_c, b_c;
   logic [7:0]    nframes_q;
   pat_e          pat_q;
   logic          stop_q, run, frame_end, last_frame, de_c, hs_c, vs_c;

   assign run        = state == ST_RUN;
   assign frame_end  = run && h_cnt == H_LAST && v_cnt == V_LAST;
   assign last_frame = stop_q || i_stop || (nframes_q != 8'd0 && frame_cnt + 1'b1 == DW'(nframes_q));
   assign hs_c       = run && h_cnt < H_SW;
   assign vs_c       = run && v_cnt < V_SW;
   assign de_c       = run && h_cnt >= H_A0 && h_cnt < H_A1 && v_cnt >= V_A0 && v_cnt < V_A1;
   assign x          = DW'(h_cnt) - DW'(HSW + HBP);
   assign y          = DW'(v_cnt) - DW'(VSW + VBP);

   // Counters sit at (0,0) while idle, so a start only has to flip the state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         h_cnt     <= '0;
         v_cnt     <= '0;
         frame_cnt <= '0;
         nframes_q <= '0;
         pat_q     <= PAT_RAMP;
         stop_q    <= 1'b0;
      end else if (!run) begin
         if (i_start) begin
            state     <= ST_RUN;
            frame_cnt <= '0;
            nframes_q <= i_nframes;
            pat_q     <= pat_e'(i_pat_sel);
            stop_q    <= 1'b0;
         end
      end else begin
         stop_q <= stop_q || i_stop;
         h_cnt  <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
         if (h_cnt == H_LAST)
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         if (frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
            pat_q     <= pat_e'(i_pat_sel);
            if (last_frame) begin
               state  <= ST_IDLE;
               stop_q <= 1'b0;
            end
         end
      end
   end

   video_pattern_gen #(.HACT(HACT)) u_pat (
      .clk     (clk),
      .rstn    (rstn),
      .i_x     (x),
      .i_y     (y),
      .i_frame (frame_cnt),
      .i_pat   (pat_q),
      .i_de    (de_c),
      .o_r     (r_c),
      .o_g     (g_c),
      .o_b     (b_c)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_vsync      <= VSYNC_POL;
         o_hsync      <= HSYNC_POL;
         o_de         <= 1'b0;
         o_r_data     <= '0;
         o_g_data     <= '0;
         o_b_data     <= '0;
      end else begin
         o_busy       <= run;
         o_frame_done <= frame_end;
         o_vsync      <= vs_c ^ VSYNC_POL;
         o_hsync      <= hs_c ^ HSYNC_POL;
         o_de         <= de_c;
         o_r_data     <= r_c;
         o_g_data     <= g_c;
         o_b_data     <= b_c;
      end
   end
endmodule

// File: tb/tb_video_timing_src.sv
// tb_video_timing_src: checks two configurations (default, and HACT=16 with inverted syncs) against a frame-position model.
module tb_video_timing_src;
   localparam int HSW = 1, HBP = 2, HFP = 2, VSW = 1, VBP = 1, VACT = 4, VFP = 1;
   localparam int VTOT = VSW + VBP + VACT + VFP;

   typedef struct packed {
      logic vs, hs, de, busy, fd;
      logic [9:0] r, g, b;
   } vo_t;

   logic clk = 1'b0, rstn = 1'b0, i_start = 1'b0, i_stop = 1'b0;
   logic [7:0] i_nframes = '0;
   logic [1:0] i_pat_sel = '0;
   logic a_busy, a_fd, a_vs, a_hs, a_de, b_busy, b_fd, b_vs, b_hs, b_de;
   logic [9:0] a_r, a_g, a_b, b_r, b_g, b_b;

   int n_checks = 0, n_fail = 0, cyc = 0;
   bit m_act[2];
   int m_t[2], m_nfr[2], m_stop[2];
   int m_pats[2][64];
   int busy_cnt[2];
   logic [29:0] px0[$], px1[$];
   int fd0_t[$];

   always #5 clk = ~clk;

   video_timing_src u_a (
      .clk(clk), .rstn(rstn), .i_start(i_start), .i_stop(i_stop), .i_nframes(i_nframes),
      .i_pat_sel(i_pat_sel), .o_busy(a_busy), .o_frame_done(a_fd), .o_vsync(a_vs),
      .o_hsync(a_hs), .o_de(a_de), .o_r_data(a_r), .o_g_data(a_g), .o_b_data(a_b)
   );

   video_timing_src #(.VSYNC_POL(1'b1), .HSYNC_POL(1'b1), .HACT(16)) u_b (
      .clk(clk), .rstn(rstn), .i_start(i_start), .i_stop(i_stop), .i_nframes(i_nframes),
      .i_pat_sel(i_pat_sel), .o_busy(b_busy), .o_frame_done(b_fd), .o_vsync(b_vs),
      .o_hsync(b_hs), .o_de(b_de), .o_r_data(b_r), .o_g_data(b_g), .o_b_data(b_b)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vo_t idle_out(input bit pol);
      vo_t o;
      o = '0;
      o.vs = pol;
      o.hs = pol;
      return o;
   endfunction

   // Expected outputs for output index k since start, from raster geometry alone.
   function automatic vo_t pos_out(input int hact, input bit pol, input int k, input int pat);
      vo_t o;
      int htot, fl, p, h, v, x, y, bw, idx;
      htot = HSW + HBP + hact + HFP;
      fl   = htot * VTOT;
      p    = k % fl;
      h    = p % htot;
      v    = p / htot;
      x    = h - HSW - HBP;
      y    = v - VSW - VBP;
      bw   = (hact / 8 < 1) ? 1 : hact / 8;
      idx  = (x / bw > 7) ? 7 : x / bw;
      o    = '0;
      o.busy = 1'b1;
      o.fd   = (p == fl - 1);
      o.hs   = (h < HSW) ^ pol;
      o.vs   = (v < VSW) ^ pol;
      o.de   = x >= 0 && x < hact && y >= 0 && y < VACT;
      if (o.de) begin
         if (pat == 0) begin
            o.r = 10'(x); o.g = 10'(y); o.b = 10'(k / fl);
         end else if (pat == 1) begin
            o.r = ((idx & 2) == 0) ? 10'h3FF : 10'h0;
            o.g = ((idx & 4) == 0) ? 10'h3FF : 10'h0;
            o.b = ((idx & 1) == 0) ? 10'h3FF : 10'h0;
         end else if (pat == 2) begin
            o.r = (((x ^ y) & 8) != 0) ? 10'h3FF : 10'h0;
            o.g = o.r;
            o.b = o.r;
         end
      end
      return o;
   endfunction

   function automatic logic [29:0] pick(input logic [29:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 30'h3FFFFFFF;
   endfunction

   function automatic int qi(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   always @(posedge clk) begin
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         vo_t e, a;
         int hact, fl, t, f;
         bit pol;
         hact = (i == 0) ? 10 : 16;
         pol  = (i == 1);
         fl   = (HSW + HBP + hact + HFP) * VTOT;
         a = (i == 0) ? {a_vs, a_hs, a_de, a_busy, a_fd, a_r, a_g, a_b}
                      : {b_vs, b_hs, b_de, b_busy, b_fd, b_r, b_g, b_b};
         if (!rstn) begin
            m_act[i] = 1'b0;
            e = idle_out(pol);
         end else if (!m_act[i]) begin
            e = idle_out(pol);
            if (i_start) begin
               m_act[i]     = 1'b1;
               m_t[i]       = 0;
               m_nfr[i]     = int'(i_nframes);
               m_stop[i]    = -1;
               m_pats[i][0] = int'(i_pat_sel);
            end
         end else begin
            m_t[i]++;
            t = m_t[i];
            if (i_stop && m_stop[i] < 0) m_stop[i] = t;
            e = pos_out(hact, pol, t - 1, m_pats[i][((t - 1) / fl) % 64]);
            if (t % fl == 0) begin
               f = t / fl - 1;
               if ((m_nfr[i] != 0 && f + 1 == m_nfr[i]) || m_stop[i] >= 0) m_act[i] = 1'b0;
               else m_pats[i][(f + 1) % 64] = int'(i_pat_sel);
            end
         end
         chk($sformatf("u%0d_outputs_cyc%0d", i, cyc), 64'(a), 64'(e));
      end
      if (a_busy) busy_cnt[0]++;
      if (b_busy) busy_cnt[1]++;
      if (a_de) px0.push_back({a_r, a_g, a_b});
      if (b_de) px1.push_back({b_r, b_g, b_b});
      if (a_fd) fd0_t.push_back(cyc);
   end

   task automatic run(input int n, input int pat);
      @(negedge clk);
      busy_cnt = '{0, 0};
      px0.delete();
      px1.delete();
      fd0_t.delete();
      i_start   = 1'b1;
      i_nframes = 8'(n);
      i_pat_sel = 2'(pat);
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int c;
      c = 0;
      repeat (2) @(negedge clk);
      while ((a_busy || b_busy) && c < lim) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (a_busy || b_busy) begin
         n_fail++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      busy_cnt = '{0, 0};
      repeat (200) @(negedge clk);
      chk("idle_busy_cycles", busy_cnt[0] + busy_cnt[1], 0);

      run(1, 0);
      wait_idle(400);
      chk("A_busy_cycles", busy_cnt[0], 105);
      chk("A_busy_cycles_b", busy_cnt[1], 147);
      chk("A_de_cycles", px0.size(), 40);
      chk("A_frame_done", fd0_t.size(), 1);
      chk("A_first_px", pick(px0, 0), 30'd0);
      chk("A_last_px", pick(px0, 39), {10'd9, 10'd3, 10'd0});

      run(3, 0);
      repeat (60) @(negedge clk);
      i_start   = 1'b1;
      i_nframes = 8'd1;
      @(negedge clk);
      i_start = 1'b0;
      wait_idle(1000);
      chk("B_frame_done", fd0_t.size(), 3);
      chk("B_fd_gap1", qi(fd0_t, 1) - qi(fd0_t, 0), 105);
      chk("B_fd_gap2", qi(fd0_t, 2) - qi(fd0_t, 1), 105);
      chk("B_busy_cycles", busy_cnt[0], 315);
      chk("B_px_f0", pick(px0, 0), {10'd0, 10'd0, 10'd0});
      chk("B_px_f1", pick(px0, 40), {10'd0, 10'd0, 10'd1});
      chk("B_px_f2", pick(px0, 80), {10'd0, 10'd0, 10'd2});

      run(0, 1);
      repeat (149) @(negedge clk);
      i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;
      wait_idle(600);
      chk("C_busy_cycles", busy_cnt[0], 210);
      chk("C_busy_cycles_b", busy_cnt[1], 294);
      chk("C_bar_white", pick(px1, 0), {10'h3FF, 10'h3FF, 10'h3FF});
      chk("C_bar_white2", pick(px1, 1), {10'h3FF, 10'h3FF, 10'h3FF});
      chk("C_bar_yellow", pick(px1, 2), {10'h3FF, 10'h3FF, 10'h0});
      chk("C_bar_cyan", pick(px1, 4), {10'h0, 10'h3FF, 10'h3FF});
      chk("C_bar_black", pick(px1, 15), 30'd0);
      chk("C_narrow_yellow", pick(px0, 1), {10'h3FF, 10'h3FF, 10'h0});
      chk("C_narrow_clamp", pick(px0, 9), 30'd0);

      run(2, 2);
      repeat (50) @(negedge clk);
      i_pat_sel = 2'd3;
      wait_idle(600);
      chk("D_de_cycles_b", px1.size(), 128);
      chk("D_chk_x7", pick(px1, 7), 30'd0);
      chk("D_chk_x8", pick(px1, 8), {10'h3FF, 10'h3FF, 10'h3FF});
      chk("D_chk_a_x8", pick(px0, 8), {10'h3FF, 10'h3FF, 10'h3FF});
      chk("D_black_f1", pick(px1, 72), 30'd0);

      run(0, 0);
      repeat (60) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("E_vsync_b", b_vs, 1'b1);
      chk("E_hsync_b", b_hs, 1'b1);
      chk("E_busy_a", a_busy, 1'b0);
      chk("E_de_a", a_de, 1'b0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      chk("E_idle_after", {a_busy, b_busy}, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
